// File: rtl/spc_pkg.sv
// Shared types and parameter table for the synth front-panel controller.
package spc_pkg;

  typedef enum logic [1:0] {ST_BROWSE, ST_EDIT, ST_COMMIT} state_e;
  typedef enum logic {MODE_SAT, MODE_WRAP} mode_e;

  localparam int unsigned NUM_PARAMS = 4;

  localparam logic [1:0] IDX_VOL   = 2'd0;
  localparam logic [1:0] IDX_OCT   = 2'd1;
  localparam logic [1:0] IDX_WAVE  = 2'd2;
  localparam logic [1:0] IDX_TEMPO = 2'd3;

  localparam int unsigned PARAM_MAX  [NUM_PARAMS] = '{15, 7, 3, 19};
  localparam int unsigned PARAM_DFLT [NUM_PARAMS] = '{8, 4, 0, 10};
  localparam mode_e       PARAM_MODE [NUM_PARAMS] = '{MODE_SAT, MODE_SAT, MODE_WRAP, MODE_WRAP};

  localparam logic [1:0] LED_BROWSE = 2'b00;
  localparam logic [1:0] LED_EDIT   = 2'b01;
  localparam logic [1:0] LED_COMMIT = 2'b10;

  // One detent of adjustment, honouring the parameter's clamp or wrap rule.
  function automatic int unsigned adjust_value(int unsigned v, logic [1:0] idx, logic up);
    int unsigned mx;
    logic        wrap;
    mx   = PARAM_MAX[idx];
    wrap = (PARAM_MODE[idx] == MODE_WRAP);
    if (up) return (v >= mx) ? (wrap ? 0 : mx) : v + 1;
    else    return (v == 0)  ? (wrap ? mx : 0) : v - 1;
  endfunction

endpackage

// File: rtl/quad_step_decoder.sv
// Rotary encoder front end: 2-FF synchronisers on A/B and a 7-state
// quadrature decoder that emits one registered step pulse per full detent.
module quad_step_decoder (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_a,
  input  logic enc_b,
  output logic step_up,
  output logic step_dn
);

  typedef enum logic [2:0] {Q_IDLE, Q_R1, Q_R2, Q_R3, Q_L1, Q_L2, Q_L3} qstate_e;

  logic [1:0] a_sync_q, b_sync_q;
  logic [1:0] ab;
  qstate_e    state_q, state_d;
  logic       up_q, up_d, dn_q, dn_d;

  assign ab      = {a_sync_q[1], b_sync_q[1]};
  assign step_up = up_q;
  assign step_dn = dn_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sync_q <= '1;
      b_sync_q <= '1;
      state_q  <= Q_IDLE;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[0], enc_a};
      b_sync_q <= {b_sync_q[0], enc_b};
      state_q  <= state_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
    end
  end

  // Forward moves advance, a reversal falls back one state; anything else holds.
  always_comb begin
    state_d = state_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    case (state_q)
      Q_IDLE: if (ab == 2'b10) state_d = Q_R1; else if (ab == 2'b01) state_d = Q_L1;
      Q_R1:   if (ab == 2'b00) state_d = Q_R2; else if (ab == 2'b11) state_d = Q_IDLE;
      Q_R2:   if (ab == 2'b01) state_d = Q_R3; else if (ab == 2'b10) state_d = Q_R1;
      Q_R3:   if (ab == 2'b11) begin state_d = Q_IDLE; up_d = 1'b1; end
              else if (ab == 2'b00) state_d = Q_R2;
      Q_L1:   if (ab == 2'b00) state_d = Q_L2; else if (ab == 2'b11) state_d = Q_IDLE;
      Q_L2:   if (ab == 2'b10) state_d = Q_L3; else if (ab == 2'b01) state_d = Q_L1;
      Q_L3:   if (ab == 2'b11) begin state_d = Q_IDLE; dn_d = 1'b1; end
              else if (ab == 2'b00) state_d = Q_L2;
      default: state_d = Q_IDLE;
    endcase
  end

endmodule

// File: rtl/synth_param_ctrl.sv
// Front-panel parameter controller: button debounce plus browse/edit/commit FSM.
// Optional EDIT inactivity timeout is enabled by defining SPC_TIMEOUT_EN.
module synth_param_ctrl
  import spc_pkg::*;
#(
  parameter int unsigned VAL_W           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_btn,
  output logic             cfg_valid,
  input  logic             cfg_ready,
  output logic [1:0]       cfg_addr,
  output logic [VAL_W-1:0] cfg_data,
  output logic [1:0]       sel_idx,
  output logic [VAL_W-1:0] edit_val,
  output logic [1:0]       led
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic step_up, step_dn;

  quad_step_decoder u_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  logic [1:0]    btn_sync_q;
  logic          db_q, db_d, press_q, press_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    db_cnt_d = '0;
    db_d     = db_q;
    press_d  = 1'b0;
    if (btn_sync_q[1] != db_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_d    = btn_sync_q[1];
        press_d = btn_sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d, addr_q, addr_d;
  logic [VAL_W-1:0] edit_q, edit_d, data_q, data_d;
  logic             valid_q, valid_d;
  logic [VAL_W-1:0] shadow_q [NUM_PARAMS];
  logic [VAL_W-1:0] shadow_d [NUM_PARAMS];

`ifdef SPC_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;

  always_comb begin
    to_d = '0;
    if (state_q == ST_EDIT && !press_q && !step_up && !step_dn) to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Press has priority over a step arriving in the same cycle.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    edit_d   = edit_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_BROWSE: begin
        if (press_q)      state_d = ST_EDIT;
        else if (step_up) sel_d = sel_q + 2'd1;
        else if (step_dn) sel_d = sel_q - 2'd1;
        edit_d = shadow_q[sel_d];
      end
      ST_EDIT: begin
        if (press_q) begin
          state_d = ST_COMMIT;
          valid_d = 1'b1;
          addr_d  = sel_q;
          data_d  = edit_q;
        end else if (step_up || step_dn) begin
          edit_d = VAL_W'(adjust_value(32'(edit_q), sel_q, step_up));
        end
`ifdef SPC_TIMEOUT_EN
        else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_BROWSE;
          edit_d  = shadow_q[sel_q];
        end
`endif
      end
      ST_COMMIT: begin
        if (valid_q && cfg_ready) begin
          valid_d         = 1'b0;
          shadow_d[sel_q] = edit_q;
          state_d         = ST_BROWSE;
        end
      end
      default: state_d = ST_BROWSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_sync_q <= '0;
      db_q       <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      state_q    <= ST_BROWSE;
      sel_q      <= IDX_VOL;
      edit_q     <= VAL_W'(PARAM_DFLT[IDX_VOL]);
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      for (int unsigned i = 0; i < NUM_PARAMS; i++) shadow_q[i] <= VAL_W'(PARAM_DFLT[i]);
    end else begin
      btn_sync_q <= {btn_sync_q[0], enc_btn};
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
      edit_q     <= edit_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      shadow_q   <= shadow_d;
    end
  end

  assign cfg_valid = valid_q;
  assign cfg_addr  = addr_q;
  assign cfg_data  = data_q;
  assign sel_idx   = sel_q;
  assign edit_val  = edit_q;

  always_comb begin
    led = LED_BROWSE;
    case (state_q)
      ST_EDIT:   led = LED_EDIT;
      ST_COMMIT: led = LED_COMMIT;
      default:   led = LED_BROWSE;
    endcase
  end

endmodule

// File: tb/tb_synth_param_ctrl.sv
// Directed self-checking bench for synth_param_ctrl.
module tb_synth_param_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, enc_a, enc_b, enc_btn, cfg_ready;
  logic       cfg_valid;
  logic [1:0] cfg_addr, sel_idx, led;
  logic [4:0] cfg_data, edit_val;

  int nvec = 0;
  int nerr = 0;
  int vcnt = 0;
  int wcnt = 0;
  int v0, w0;

  synth_param_ctrl #(
    .VAL_W           (5),
    .DEBOUNCE_CYCLES (16),
    .TIMEOUT_CYCLES  (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .enc_btn   (enc_btn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .sel_idx   (sel_idx),
    .edit_val  (edit_val),
    .led       (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cfg_valid) vcnt++;
    if (cfg_valid && cfg_ready) wcnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic phase(input logic a, input logic b);
    enc_a = a;
    enc_b = b;
    tick(20);
  endtask

  task automatic cw();
    phase(1, 0); phase(0, 0); phase(0, 1); phase(1, 1);
  endtask

  task automatic ccw();
    phase(0, 1); phase(0, 0); phase(1, 0); phase(1, 1);
  endtask

  task automatic press();
    enc_btn = 1'b1;
    tick(20);
    enc_btn = 1'b0;
    tick(20);
  endtask

  // Press from EDIT, stall cfg_ready for 'delay' cycles after valid appears.
  task automatic commit_wait(input int delay, input int exp_addr, input int exp_data);
    int t;
    v0 = vcnt;
    w0 = wcnt;
    enc_btn = 1'b1;
    t = 0;
    while (!cfg_valid && t < 60) begin
      tick(1);
      t++;
    end
    check("commit_valid_rise", cfg_valid, 1);
    check("commit_led", led, 2);
    tick(delay);
    check("commit_valid_held", cfg_valid, 1);
    check("commit_addr", cfg_addr, exp_addr);
    check("commit_data", cfg_data, exp_data);
    cfg_ready = 1'b1;
    tick(1);
    cfg_ready = 1'b0;
    check("commit_valid_cycles", vcnt - v0, delay + 1);
    check("commit_write_count", wcnt - w0, 1);
    check("commit_valid_drop", cfg_valid, 0);
    enc_btn = 1'b0;
    tick(20);
    check("commit_back_browse", led, 0);
  endtask

  task automatic commit_ready_high();
    v0 = vcnt;
    w0 = wcnt;
    cfg_ready = 1'b1;
    press();
    cfg_ready = 1'b0;
    check("fastcommit_valid_cycles", vcnt - v0, 1);
    check("fastcommit_writes", wcnt - w0, 1);
    check("fastcommit_led", led, 0);
  endtask

  initial begin
    rst_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1; enc_btn = 1'b0; cfg_ready = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(1);
    check("rst_valid", cfg_valid, 0);
    check("rst_addr", cfg_addr, 0);
    check("rst_data", cfg_data, 0);
    check("rst_sel", sel_idx, 0);
    check("rst_edit", edit_val, 8);
    check("rst_led", led, 0);

    cw();
    check("cw1_sel", sel_idx, 1);
    check("cw1_edit", edit_val, 4);

    press();
    check("oct_edit_led", led, 1);
    ccw(); check("oct_dn1", edit_val, 3);
    ccw(); check("oct_dn2", edit_val, 2);
    ccw(); check("oct_dn3", edit_val, 1);
    check("oct_sel_kept", sel_idx, 1);
    commit_wait(5, 1, 1);
    check("oct_shadow_sel", sel_idx, 1);
    check("oct_shadow_edit", edit_val, 1);

    cw();
    check("wave_sel", sel_idx, 2);
    check("wave_dflt", edit_val, 0);
    press();
    cw(); check("wave_1", edit_val, 1);
    cw(); check("wave_2", edit_val, 2);
    cw(); check("wave_3", edit_val, 3);
    cw(); check("wave_wrap0", edit_val, 0);
    cw(); check("wave_1b", edit_val, 1);
    commit_ready_high();
    check("wave_shadow", edit_val, 1);

    ccw(); check("back_oct", edit_val, 1);
    ccw();
    check("vol_sel", sel_idx, 0);
    check("vol_dflt", edit_val, 8);
    press();
    for (int i = 1; i <= 10; i++) begin
      cw();
      check("vol_sat", edit_val, (8 + i > 15) ? 15 : 8 + i);
    end
    commit_ready_high();

    phase(1, 0); phase(0, 0); phase(1, 0); phase(1, 1);
    check("partial_sel", sel_idx, 0);
    check("partial_edit", edit_val, 15);

    ccw();
    check("sel_wrap_dn", sel_idx, 3);
    check("tempo_dflt", edit_val, 10);
    cw();
    check("sel_wrap_up", sel_idx, 0);

    repeat (4) begin
      enc_btn = 1'b1; tick(5);
      enc_btn = 1'b0; tick(5);
    end
    tick(20);
    check("bounce_no_press", led, 0);
    enc_btn = 1'b1; tick(15);
    enc_btn = 1'b0; tick(30);
    check("hold15_no_press", led, 0);
    enc_btn = 1'b1; tick(16);
    enc_btn = 1'b0; tick(30);
    check("hold16_press", led, 1);
    check("hold16_edit", edit_val, 15);

    // Final B rise timed so step_dn and press pulse land in the same cycle.
    phase(0, 1); phase(0, 0); phase(1, 0);
    enc_btn = 1'b1;
    tick(15);
    enc_b = 1'b1;
    tick(10);
    check("coinc_led", led, 2);
    check("coinc_edit", edit_val, 15);
    check("coinc_valid", cfg_valid, 1);
    check("coinc_data", cfg_data, 15);
    enc_btn = 1'b0;
    tick(20);
    check("commit_holds", led, 2);

    w0 = wcnt;
    rst_n = 1'b0;
    tick(1);
    check("rst_commit_valid", cfg_valid, 0);
    rst_n = 1'b1;
    tick(1);
    check("rst_commit_edit", edit_val, 8);
    check("rst_commit_led", led, 0);
    check("rst_commit_nowrite", wcnt - w0, 0);

    ccw();
    check("to_sel", sel_idx, 3);
    press();
    check("to_edit_led", led, 1);
    cw(); check("to_tempo11", edit_val, 11);
    cw(); check("to_tempo12", edit_val, 12);
    v0 = vcnt;
    tick(100);
`ifdef SPC_TIMEOUT_EN
    check("timeout_led", led, 0);
    check("timeout_edit", edit_val, 10);
    check("timeout_novalid", vcnt - v0, 0);
`else
    check("no_timeout_led", led, 1);
    check("no_timeout_edit", edit_val, 12);
    check("no_timeout_novalid", vcnt - v0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
